// File: rtl/seq_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier_pkg
// Brief    : Shared types and constants for the sequential shift-add multiplier
// Revision : 1.0 - initial release
// ============================================================================
package seq_multiplier_pkg;

    localparam int unsigned c_DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mulState_t;

    // Counter must hold 0..n-1; keep at least one bit for degenerate sizes.
    function automatic int unsigned cntWidth(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned c_CNT_W = cntWidth(c_DEF_WIDTH);

endpackage
`default_nettype wire

// File: rtl/seq_mul_datapath.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_datapath
// Brief    : Operand magnitude registers, shift-add accumulator, sign fix-up
// Revision : 1.0 - initial release
// ============================================================================
module seq_mul_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_finish,
    input  logic                 i_isSigned,
    input  logic [WIDTH-1:0]     i_dataA,
    input  logic [WIDTH-1:0]     i_dataB,
    output logic [2*WIDTH-1:0]   o_mulAns
);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mulAns;
    logic               r_neg;

    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_accNext;
    logic [2*WIDTH-1:0] w_final;

    // The most negative operand negates to itself, which read unsigned is 2^(W-1).
    always_comb begin
        w_magA    = (i_isSigned && i_dataA[WIDTH-1]) ? (~i_dataA + WIDTH'(1)) : i_dataA;
        w_magB    = (i_isSigned && i_dataB[WIDTH-1]) ? (~i_dataB + WIDTH'(1)) : i_dataB;
        w_addend  = r_mplier[0] ? r_mcand : '0;
        w_accNext = r_acc + w_addend;
        w_final   = r_neg ? (~w_accNext + (2*WIDTH)'(1)) : w_accNext;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
        end else if (i_load) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_magA};
            r_mplier <= w_magB;
            r_acc    <= '0;
            r_neg    <= i_isSigned & (i_dataA[WIDTH-1] ^ i_dataB[WIDTH-1]);
        end else if (i_step) begin
            r_acc    <= w_accNext;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
        end
    end

    // Result register only moves on the final iteration edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mulAns <= '0;
        end else if (i_finish) begin
            r_mulAns <= w_final;
        end
    end

    assign o_mulAns = r_mulAns;

endmodule
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Brief    : Fixed-latency signed/unsigned sequential multiplier (FSM + counter)
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEF_WIDTH,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   MulAns
);

    localparam int unsigned c_CNT_WIDTH = (ITER == c_DEF_WIDTH) ? c_CNT_W : cntWidth(ITER);
    localparam logic [c_CNT_WIDTH-1:0] c_LAST = c_CNT_WIDTH'(ITER - 1);

    mulState_t              r_state;
    mulState_t              w_nextState;
    logic [c_CNT_WIDTH-1:0] r_count;
    logic                   w_accept;
    logic                   w_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (r_count == c_LAST) begin
                    w_last      = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = BUSY;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= '0;
        end else if (r_state == BUSY) begin
            r_count <= r_count + c_CNT_WIDTH'(1);
        end
    end

    assign busy = (r_state == BUSY);
    assign done = (r_state == DONE);

    seq_mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_step     (r_state == BUSY),
        .i_finish   (w_last),
        .i_isSigned (is_signed),
        .i_dataA    (dataA),
        .i_dataB    (dataB),
        .o_mulAns   (MulAns)
    );

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier
// Brief    : Scoreboard bench for seq_multiplier with directed vectors
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int unsigned c_W = 32;

    typedef struct {
        logic [2*c_W-1:0] val;
        int               acceptCyc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic             is_signed;
    logic [c_W-1:0]   dataA;
    logic [c_W-1:0]   dataB;
    logic             busy;
    logic             done;
    logic [2*c_W-1:0] MulAns;

    exp_t             sb[$];
    int               vectors = 0;
    int               fails   = 0;
    int               cyc     = 0;
    logic [2*c_W-1:0] prevMul = '0;

    seq_multiplier #(
        .WIDTH (c_W),
        .ITER  (c_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dataA     (dataA),
        .dataB     (dataB),
        .busy      (busy),
        .done      (done),
        .MulAns    (MulAns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected results on done, checks value, latency, exclusivity, stability.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prevMul = MulAns;
        end else begin
            if (done) begin
                vectors++;
                if (busy) begin
                    fails++;
                    $display("FAIL busy_done_overlap: busy=%0b done=%0b, required busy=0", busy, done);
                end
                vectors++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: MulAns=%h at cycle %0d, no result pending", MulAns, cyc);
                end else begin
                    e = sb.pop_front();
                    if (MulAns !== e.val) begin
                        fails++;
                        $display("FAIL product: MulAns=%h, required %h", MulAns, e.val);
                    end
                    vectors++;
                    if (cyc != e.acceptCyc + 32) begin
                        fails++;
                        $display("FAIL latency: done at edge %0d, required edge %0d", cyc, e.acceptCyc + 32);
                    end
                end
            end else if (MulAns !== prevMul) begin
                vectors++;
                fails++;
                $display("FAIL mulans_stable: MulAns=%h changed without done, required %h", MulAns, prevMul);
            end
            prevMul = MulAns;
        end
    end

    task automatic issue(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                         input logic sgn, input logic [2*c_W-1:0] expVal);
        exp_t e;
        @(negedge clk);
        dataA     = a;
        dataB     = b;
        is_signed = sgn;
        start     = 1'b1;
        @(posedge clk);
        #1;
        e.val       = expVal;
        e.acceptCyc = cyc;
        sb.push_back(e);
        start = 1'b0;
    endtask

    // Same as issue() but leaves start high so the next accept happens from DONE.
    task automatic issueHeld(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                             input logic sgn, input logic [2*c_W-1:0] expVal);
        exp_t e;
        dataA     = a;
        dataB     = b;
        is_signed = sgn;
        start     = 1'b1;
        @(posedge clk);
        #1;
        e.val       = expVal;
        e.acceptCyc = cyc;
        sb.push_back(e);
    endtask

    task automatic waitDone();
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            fails++;
            $display("FAIL done_timeout: no done within 40 cycles, required one");
        end
    endtask

    task automatic checkVal(input string name, input logic [2*c_W-1:0] act,
                            input logic [2*c_W-1:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dataA     = '0;
        dataB     = '0;
        #1 reset  = 1'b0;
        #1;
        checkVal("reset_busy",   {63'd0, busy},   64'd0);
        checkVal("reset_done",   {63'd0, done},   64'd0);
        checkVal("reset_mulans", MulAns,          64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        issue(32'd3,          32'd5,          1'b0, 64'h0000_0000_0000_000F); waitDone();
        issue(32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1); waitDone();
        issue(32'hFFFF_FFFD,  32'd5,          1'b0, 64'h0000_0004_FFFF_FFF1); waitDone();
        issue(32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000); waitDone();
        issue(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001); waitDone();
        issue(32'd0,          32'h1234_5678,  1'b0, 64'h0000_0000_0000_0000); waitDone();
        issue(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_0000_0001); waitDone();
        issue(32'd7,          32'hFFFF_FFFA,  1'b1, 64'hFFFF_FFFF_FFFF_FFD6); waitDone();
        issue(32'h8000_0000,  32'd1,          1'b1, 64'hFFFF_FFFF_8000_0000); waitDone();

        // A start with fresh operands during BUSY must be ignored.
        issue(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
        repeat (9) @(negedge clk);
        dataA     = 32'h0000_DEAD;
        dataB     = 32'h0000_BEEF;
        is_signed = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone();
        repeat (40) @(negedge clk);

        // Abort mid-operation: outputs clear without a clock edge.
        issue(32'h0000_1234, 32'h0000_0010, 1'b0, 64'h0000_0000_0001_2340);
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkVal("abort_busy",   {63'd0, busy}, 64'd0);
        checkVal("abort_done",   {63'd0, done}, 64'd0);
        checkVal("abort_mulans", MulAns,        64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A);
        waitDone();

        // Start held high across three operations: results at N+32, N+65, N+98.
        @(negedge clk);
        issueHeld(32'h1234_5678, 32'd2,         1'b0, 64'h0000_0000_2468_ACF0);
        waitDone();
        issueHeld(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001);
        waitDone();
        issueHeld(32'hFFFF_FFFF, 32'd0,         1'b0, 64'h0000_0000_0000_0000);
        start = 1'b0;
        waitDone();
        repeat (40) @(negedge clk);

        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            fails++;
            $display("FAIL missing_result: no done seen, required MulAns=%h", e.val);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
